mp_memory: RTL

//  Parametrised multi-port word memory; successor to the multicycle core's dual-port memory.
//  One byte-enabled write port and NUM_RD read channels with valid/ready request handshakes.

---
 rtl/mp_memory.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mp_memory.sv
// mp_memory: parametrised multi-port word memory.
//
// One byte-enabled write port plus NUM_RD read channels with valid/ready
// request handshakes. Channel 0 shares the physical write port, so it is
// back-pressured (rd_ready[0]=0) whenever a write is presented. Read data
// returns RD_LAT cycles after acceptance (1 or 2), fully pipelined and
// in order. Same-cycle write-to-read forwarding is write-first.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   wr_en/addr/data/be    write request (byte address, byte enables)
//   wr_err                one-cycle pulse: last cycle's write was misaligned and dropped
//   rd_req/rd_ready       per-channel request handshake
//   rd_addr               per-channel byte address, channel c at [32c+31:32c]
//   rd_rvalid/data/err    per-channel response strobe, data, misaligned flag
module mp_memory #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int NUM_RD    = 2,
  parameter int RD_LAT    = 1,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [31:0]              wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  output logic                     wr_err,
  input  logic [NUM_RD-1:0]        rd_req,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_RD*32-1:0]     rd_addr,
  output logic [NUM_RD-1:0]        rd_rvalid,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_idx;
  logic              wr_mis;
  logic              wr_do;
  logic [DATA_W-1:0] wr_merged;

  // Address bits above the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr, rd_addr};

  assign wr_idx = wr_addr[ADDR_W+1:2];
  assign wr_mis = |wr_addr[1:0];
  assign wr_do  = wr_en & ~wr_mis;

  // Post-write image of the addressed word, used for forwarding.
  always_comb begin
    wr_merged = mem[wr_idx];
    for (int b = 0; b < BE_W; b++) begin
      if (wr_be[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_do) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err <= 1'b0;
    else        wr_err <= wr_en & wr_mis;
  end

  // Channel 0 shares the write port, so any write stalls it.
  always_comb begin
    rd_ready    = '1;
    rd_ready[0] = ~wr_en;
  end

  generate
    for (genvar c = 0; c < NUM_RD; c++) begin : g_rd
      logic [ADDR_W-1:0] idx;
      logic              mis;
      logic              acc;
      logic [DATA_W-1:0] word;
      logic              s1_v;
      logic              s1_e;
      logic [DATA_W-1:0] s1_d;

      assign idx  = rd_addr[32*c+2 +: ADDR_W];
      assign mis  = |rd_addr[32*c +: 2];
      assign acc  = rd_req[c] & rd_ready[c];
      assign word = (wr_do && (idx == wr_idx)) ? wr_merged : mem[idx];

      // Data only loads on accept so the output holds between responses.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_v <= 1'b0;
          s1_e <= 1'b0;
          s1_d <= '0;
        end else begin
          s1_v <= acc;
          s1_e <= acc & mis;
          if (acc) s1_d <= word;
        end
      end

      if (RD_LAT == 2) begin : g_lat2
        logic              s2_v;
        logic              s2_e;
        logic [DATA_W-1:0] s2_d;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            s2_v <= 1'b0;
            s2_e <= 1'b0;
            s2_d <= '0;
          end else begin
            s2_v <= s1_v;
            s2_e <= s1_e;
            if (s1_v) s2_d <= s1_d;
          end
        end

        assign rd_rvalid[c]               = s2_v;
        assign rd_err[c]                  = s2_e;
        assign rd_data[DATA_W*c +: DATA_W] = s2_d;
      end else begin : g_lat1
        assign rd_rvalid[c]               = s1_v;
        assign rd_err[c]                  = s1_e;
        assign rd_data[DATA_W*c +: DATA_W] = s1_d;
      end
    end
  endgenerate

endmodule
